ysyx_25020047_ifu: RTL

Instruction fetch unit, directly upstream of the decode stage. It owns the architectural PC and issues one fetch at a time to instruction memory over a valid/ready request plus valid response interface. It presents the fetched instruction, its PC and snpc (pc+4) to decode with a valid/ready handshake. After decode accepts, it waits for the committed next PC (dnpc) from the back end before fetching again (multi-cycle, non-pipelined core).

---
 rtl/ysyx_25020047_pkg.sv | 15 +
 rtl/ysyx_25020047_ifu_if.sv | 30 +++
 rtl/ysyx_25020047_ifu.sv | 81 ++++++++
 3 files changed

// File: rtl/ysyx_25020047_pkg.sv
// Shared types and constants for the ysyx_25020047 instruction fetch unit.
package ysyx_25020047_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          INST_BYTES       = 4;

  typedef enum logic [2:0] {
    ST_REQ      = 3'd0,
    ST_WAIT_RSP = 3'd1,
    ST_HOLD     = 3'd2,
    ST_WAIT_NPC = 3'd3,
    ST_FAULT    = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ysyx_25020047_ifu_if.sv
// Fetch-unit bus bundle: the instruction-memory request/response channel, the decode
// handoff and the back-end next-PC commit. The IFU uses the master modport.
interface ysyx_25020047_ifu_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] snpc;
    logic            dnpc_valid;
    logic [XLEN-1:0] dnpc;
    logic [31:0]     fetch_cnt;
    logic            fetch_fault;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, pc, snpc, fetch_cnt, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, dnpc_valid, dnpc
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, pc, snpc, fetch_cnt, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, dnpc_valid, dnpc
    );
endinterface

// File: rtl/ysyx_25020047_ifu.sv
// Non-pipelined instruction fetch unit: one fetch in flight, waits for the committed dnpc.
// Optional macro YSYX_25020047_IFU_ALIGN_CHK_EN traps misaligned dnpc into a sticky FAULT state.
module ysyx_25020047_ifu
    import ysyx_25020047_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_25020047_ifu_if.master bus
);
    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            ST_REQ: begin
                if (bus.imem_req_ready) state_d = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (bus.imem_rsp_valid) begin
                    inst_d  = bus.imem_rsp_data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.inst_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = ST_WAIT_NPC;
                end
            end
            ST_WAIT_NPC: begin
                if (bus.dnpc_valid) begin
                    pc_d = bus.dnpc;
`ifdef YSYX_25020047_IFU_ALIGN_CHK_EN
                    state_d = (bus.dnpc[1:0] != 2'b00) ? ST_FAULT : ST_REQ;
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_REQ;
        endcase
    end

    assign bus.imem_req_valid = (state_q == ST_REQ);
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = (state_q == ST_HOLD);
    assign bus.inst           = inst_q;
    assign bus.pc             = pc_q;
    assign bus.snpc           = pc_q + XLEN'(INST_BYTES);
    assign bus.fetch_cnt      = fetch_cnt_q;
`ifdef YSYX_25020047_IFU_ALIGN_CHK_EN
    assign bus.fetch_fault    = (state_q == ST_FAULT);
`else
    assign bus.fetch_fault    = 1'b0;
`endif

endmodule
